bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_if.sv | 33 +++
 rtl/bin2bcd_seq.sv | 125 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_if.sv
// Handshake bundle for bin2bcd_seq: request side (in_*) and result side (out_*, bcd, ovf).
// The sign field exists only when BIN2BCD_SIGN_EN is defined.
interface bin2bcd_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ovf;
`ifdef BIN2BCD_SIGN_EN
  logic                  sign;
`endif

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, bcd, ovf
`ifdef BIN2BCD_SIGN_EN
    , input sign
`endif
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, bcd, ovf
`ifdef BIN2BCD_SIGN_EN
    , output sign
`endif
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock, valid/ready on both sides.
// Optional macro BIN2BCD_SIGN_EN: treat in_data as two's complement and report a sign bit.
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  bin2bcd_if.slave   bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sh;
  logic [BW-1:0]    acc;
  logic             ovf_acc;
  logic [BW-1:0]    bcd_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [WIDTH-1:0] mag;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    acc_next;
  logic [WIDTH-1:0] sh_next;
  logic             ovf_next;

`ifdef BIN2BCD_SIGN_EN
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  logic sign_acc;
  logic sign_q;

  // Negating -2^(WIDTH-1) wraps to itself, which is the correct unsigned magnitude.
  assign mag = bus.in_data[WIDTH-1] ? (~bus.in_data + ONE) : bus.in_data;
  assign bus.sign = sign_q;
`else
  assign mag = bus.in_data;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    adj = acc;
    for (int k = 0; k < DIGITS; k++) begin
      if (cnt != '0 && acc[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
      end
    end
    {acc_next, sh_next} = {adj[BW-2:0], sh, 1'b0};
    ovf_next = ovf_acc | adj[BW-1];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      sh          <= '0;
      acc         <= '0;
      ovf_acc     <= 1'b0;
      bcd_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef BIN2BCD_SIGN_EN
      sign_acc    <= 1'b0;
      sign_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sh         <= mag;
            acc        <= '0;
            ovf_acc    <= 1'b0;
            cnt        <= '0;
            in_ready_q <= 1'b0;
            state      <= SHIFT;
`ifdef BIN2BCD_SIGN_EN
            sign_acc   <= bus.in_data[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          sh      <= sh_next;
          acc     <= acc_next;
          ovf_acc <= ovf_next;
          cnt     <= cnt + CNT_ONE;
          // Result registers change only here, so the consumer sees the old value while shifting.
          if (cnt == LAST) begin
            bcd_q       <= acc_next;
            ovf_q       <= ovf_next;
            out_valid_q <= 1'b1;
            state       <= DONE;
`ifdef BIN2BCD_SIGN_EN
            sign_q      <= sign_acc;
`endif
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.bcd       = bcd_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: a 3-digit and a 2-digit instance share the same stimulus,
// table-driven conversions plus hand-written backpressure and mid-conversion reset sequences.
module tb_bin2bcd_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  bin2bcd_if #(.WIDTH(8), .DIGITS(3)) a_if ();
  bin2bcd_if #(.WIDTH(8), .DIGITS(2)) b_if ();

  assign b_if.in_valid  = a_if.in_valid;
  assign b_if.in_data   = a_if.in_data;
  assign b_if.out_ready = a_if.out_ready;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

  typedef struct {
    logic [7:0]  data;
    logic [11:0] bcd3;
    logic        ovf3;
    logic [7:0]  bcd2;
    logic        ovf2;
    logic        sign;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full conversion with out_ready=1: latency, busy window and both results.
  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    int busy;
    logic [11:0] g3;
    logic [7:0]  g2;
    logic        o3, o2, s3, s2;
    s3 = 1'b0;
    s2 = 1'b0;
    g3 = '0; g2 = '0; o3 = 1'b0; o2 = 1'b0;
    check({tag, " ready_before"}, 32'(a_if.in_ready), 32'd1);
    a_if.out_ready = 1'b1;
    a_if.in_data   = v.data;
    a_if.in_valid  = 1'b1;
    @(posedge clk); #1;
    a_if.in_valid = 1'b0;
    a_if.in_data  = 8'hA5;
    lat  = -1;
    busy = 0;
    for (int k = 0; k < 64; k++) begin
      if (a_if.out_valid && lat < 0) begin
        lat = k;
        g3 = a_if.bcd; o3 = a_if.ovf;
        g2 = b_if.bcd; o2 = b_if.ovf;
`ifdef BIN2BCD_SIGN_EN
        s3 = a_if.sign; s2 = b_if.sign;
`endif
      end
      if (a_if.in_ready) break;
      busy++;
      @(posedge clk); #1;
    end
    check({tag, " latency"}, 32'(lat), 32'd8);
    check({tag, " busy"}, 32'(busy), 32'd9);
    check({tag, " bcd3"}, 32'(g3), 32'(v.bcd3));
    check({tag, " ovf3"}, 32'(o3), 32'(v.ovf3));
    check({tag, " bcd2"}, 32'(g2), 32'(v.bcd2));
    check({tag, " ovf2"}, 32'(o2), 32'(v.ovf2));
`ifdef BIN2BCD_SIGN_EN
    check({tag, " sign3"}, 32'(s3), 32'(v.sign));
    check({tag, " sign2"}, 32'(s2), 32'(v.sign));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    int   waited;
`ifdef BIN2BCD_SIGN_EN
    vecs[0] = '{8'h80, 12'h128, 1'b0, 8'h28, 1'b1, 1'b1};
    vecs[1] = '{8'hFF, 12'h001, 1'b0, 8'h01, 1'b0, 1'b1};
    vecs[2] = '{8'h00, 12'h000, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'h63, 12'h099, 1'b0, 8'h99, 1'b0, 1'b0};
    vecs[4] = '{8'h25, 12'h037, 1'b0, 8'h37, 1'b0, 1'b0};
    vecs[5] = '{8'h9C, 12'h100, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{8'h7F, 12'h127, 1'b0, 8'h27, 1'b1, 1'b0};
    vecs[7] = '{8'h81, 12'h127, 1'b0, 8'h27, 1'b1, 1'b1};
    vecs[8] = '{8'h9D, 12'h099, 1'b0, 8'h99, 1'b0, 1'b1};
    vecs[9] = '{8'h0A, 12'h010, 1'b0, 8'h10, 1'b0, 1'b0};
`else
    vecs[0] = '{8'd255, 12'h255, 1'b0, 8'h55, 1'b1, 1'b0};
    vecs[1] = '{8'd0,   12'h000, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{8'd99,  12'h099, 1'b0, 8'h99, 1'b0, 1'b0};
    vecs[3] = '{8'd1,   12'h001, 1'b0, 8'h01, 1'b0, 1'b0};
    vecs[4] = '{8'd10,  12'h010, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[5] = '{8'd128, 12'h128, 1'b0, 8'h28, 1'b1, 1'b0};
    vecs[6] = '{8'd200, 12'h200, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'd37,  12'h037, 1'b0, 8'h37, 1'b0, 1'b0};
    vecs[8] = '{8'd9,   12'h009, 1'b0, 8'h09, 1'b0, 1'b0};
    vecs[9] = '{8'd100, 12'h100, 1'b0, 8'h00, 1'b1, 1'b0};
`endif

    a_if.in_valid  = 1'b0;
    a_if.in_data   = 8'h00;
    a_if.out_ready = 1'b0;

    // Reset state
    #12;
    check("rst in_ready", 32'(a_if.in_ready), 32'd1);
    check("rst out_valid", 32'(a_if.out_valid), 32'd0);
    check("rst bcd", 32'(a_if.bcd), 32'h000);
    check("rst ovf", 32'(a_if.ovf), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      run_vec(v, $sformatf("vec%0d", i));
      @(posedge clk); #1;
    end

    // Backpressure: result held for five cycles, new request ignored while DONE.
    a_if.out_ready = 1'b0;
    a_if.in_data   = 8'd100;
    a_if.in_valid  = 1'b1;
    @(posedge clk); #1;
    a_if.in_valid = 1'b0;
    waited = 0;
    while (!a_if.out_valid && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check("bp out_valid", 32'(a_if.out_valid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      a_if.in_valid = 1'b1;
      a_if.in_data  = 8'd55;
      @(posedge clk); #1;
      check($sformatf("bp hold bcd c%0d", c), 32'(a_if.bcd), 32'h100);
      check($sformatf("bp in_ready c%0d", c), 32'(a_if.in_ready), 32'd0);
      check($sformatf("bp out_valid c%0d", c), 32'(a_if.out_valid), 32'd1);
    end
    a_if.in_valid  = 1'b0;
    a_if.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp release in_ready", 32'(a_if.in_ready), 32'd1);
    check("bp release out_valid", 32'(a_if.out_valid), 32'd0);
    check("bp release bcd", 32'(a_if.bcd), 32'h100);
    @(posedge clk); #1;
    check("bp no accept", 32'(a_if.in_ready), 32'd1);

    // Asynchronous reset in the middle of a conversion.
    a_if.in_data  = 8'd200;
    a_if.in_valid = 1'b1;
    @(posedge clk); #1;
    a_if.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst in_ready", 32'(a_if.in_ready), 32'd1);
    check("arst out_valid", 32'(a_if.out_valid), 32'd0);
    check("arst bcd", 32'(a_if.bcd), 32'h000);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post rst in_ready", 32'(a_if.in_ready), 32'd1);
    check("post rst out_valid", 32'(a_if.out_valid), 32'd0);
    check("post rst bcd", 32'(a_if.bcd), 32'h000);
    v = '{8'd37, 12'h037, 1'b0, 8'h37, 1'b0, 1'b0};
    run_vec(v, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
